// File: rtl/vector_alu_pkg.sv
// ============================================================================
// vector_alu_pkg : opcode, element-width and operand-type constants for the
//                  vector lane ALU.  Rev 1.0
// ============================================================================
`default_nettype none

package vector_alu_pkg;

  localparam logic [5:0] VECTOR_ADD   = 6'd0;
  localparam logic [5:0] VECTOR_SUB   = 6'd1;
  localparam logic [5:0] VECTOR_WADDU = 6'd2;
  localparam logic [5:0] VECTOR_WSUBU = 6'd3;
  localparam logic [5:0] VECTOR_WADD  = 6'd4;
  localparam logic [5:0] VECTOR_WSUB  = 6'd5;
  localparam logic [5:0] VECTOR_ADC   = 6'd6;
  localparam logic [5:0] VECTOR_SBC   = 6'd7;
  localparam logic [5:0] VECTOR_MSBC  = 6'd8;
  localparam logic [5:0] VECTOR_MACC  = 6'd9;
  localparam logic [5:0] VECTOR_NMSAC = 6'd10;
  localparam logic [5:0] VECTOR_MADD  = 6'd11;
  localparam logic [5:0] VECTOR_ZEXT2 = 6'd12;
  localparam logic [5:0] VECTOR_ZEXT4 = 6'd13;
  localparam logic [5:0] VECTOR_ZEXT8 = 6'd14;
  localparam logic [5:0] VECTOR_SEXT2 = 6'd15;
  localparam logic [5:0] VECTOR_SEXT4 = 6'd16;
  localparam logic [5:0] VECTOR_SEXT8 = 6'd17;

  localparam logic [2:0] ONE_BYTE   = 3'b000;
  localparam logic [2:0] TWO_BYTE   = 3'b001;
  localparam logic [2:0] FOUR_BYTE  = 3'b010;
  localparam logic [2:0] EIGHT_BYTE = 3'b011;

  localparam logic [1:0] OPIVV = 2'b00;
  localparam logic [1:0] OPIVX = 2'b01;
  localparam logic [1:0] OPIVI = 2'b10;
  localparam logic [1:0] OPMVV = 2'b11;

  localparam logic [2:0] ALU_IDLE = 3'b000;

endpackage

`default_nettype wire

// File: rtl/vec_elem_extend.sv
// ============================================================================
// vec_elem_extend : truncate a 64-bit container to an element width and
//                   zero/sign-extend it back to 64 bits.  Rev 1.0
// ============================================================================
`default_nettype none

module vec_elem_extend
  import vector_alu_pkg::*;
(
  input  logic [63:0] value,
  input  logic [2:0]  vsew,
  input  logic        sign_ext,
  output logic [63:0] out
);

  always_comb begin
    out = value;
    case (vsew)
      ONE_BYTE:  out = {{56{sign_ext & value[7]}},  value[7:0]};
      TWO_BYTE:  out = {{48{sign_ext & value[15]}}, value[15:0]};
      FOUR_BYTE: out = {{32{sign_ext & value[31]}}, value[31:0]};
      default:   out = value;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vector_lane_alu.sv
// ============================================================================
// vector_lane_alu : single-lane element ALU of the vector function unit,
//                   one registered element result per cycle.  Rev 1.0
// ============================================================================
`default_nettype none

module vector_lane_alu
  import vector_alu_pkg::*;
#(
  parameter int LANE_INDEX  = 0,
  parameter int LEN         = 32,
  parameter int LONGEST_LEN = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             PREV_VSEW,
  input  logic [2:0]             CUR_VSEW,
  input  logic                   vm,
  input  logic [LONGEST_LEN-1:0] vs1,
  input  logic [LONGEST_LEN-1:0] vs2,
  input  logic [LONGEST_LEN-1:0] mask,
  input  logic [LEN-1:0]         imm,
  input  logic [LEN-1:0]         rs,
  input  logic [2:0]             alu_signal,
  input  logic [1:0]             vec_operand_type,
  input  logic [5:0]             opcode,
  output logic [LONGEST_LEN-1:0] result
);

  logic [63:0] a_raw;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] raw;
  logic [63:0] out_val;
  logic [63:0] product;
  logic [64:0] borrow_diff;
  logic        signed_op;
  logic        invalid;
  logic        inactive;
  logic        maskable;
  logic        carry_in;
  logic [3:0]  prev_p1;
  logic [3:0]  prev_p2;
  logic [3:0]  prev_p3;
  logic [3:0]  cur_w;
  logic        cur_ok;

  always_comb begin
    case (vec_operand_type)
      OPIVX:   a_raw = {{(LONGEST_LEN-LEN){rs[LEN-1]}}, rs};
      OPIVI:   a_raw = {{(LONGEST_LEN-LEN){imm[LEN-1]}}, imm};
      default: a_raw = vs1;
    endcase
  end

  assign signed_op = (opcode == VECTOR_WADD)  || (opcode == VECTOR_WSUB) ||
                     (opcode == VECTOR_SEXT2) || (opcode == VECTOR_SEXT4) ||
                     (opcode == VECTOR_SEXT8);

  vec_elem_extend u_ext_a (.value(a_raw), .vsew(PREV_VSEW), .sign_ext(signed_op), .out(a_ext));
  vec_elem_extend u_ext_b (.value(vs2),   .vsew(PREV_VSEW), .sign_ext(signed_op), .out(b_ext));

  assign product  = a_ext * b_ext;
  assign carry_in = vm ? 1'b0 : mask[0];
  // Operands are zero-extended here, so bit 64 of the difference is the borrow-out.
  assign borrow_diff = {1'b0, b_ext} - {1'b0, a_ext} - {64'd0, carry_in};

  assign prev_p1 = {1'b0, PREV_VSEW} + 4'd1;
  assign prev_p2 = {1'b0, PREV_VSEW} + 4'd2;
  assign prev_p3 = {1'b0, PREV_VSEW} + 4'd3;
  assign cur_w   = {1'b0, CUR_VSEW};
  assign cur_ok  = (CUR_VSEW <= EIGHT_BYTE);

  assign maskable = !((opcode == VECTOR_ADC)  || (opcode == VECTOR_SBC)   ||
                      (opcode == VECTOR_MSBC) || (opcode == VECTOR_MACC)  ||
                      (opcode == VECTOR_NMSAC)|| (opcode == VECTOR_MADD));
  assign inactive = maskable && !vm && !mask[0];

  always_comb begin
    raw     = 64'd0;
    invalid = 1'b0;
    case (opcode)
      VECTOR_ADD:   raw = b_ext + a_ext;
      VECTOR_SUB:   raw = b_ext - a_ext;
      VECTOR_WADDU, VECTOR_WADD: begin
        raw     = b_ext + a_ext;
        invalid = (cur_w != prev_p1) || !cur_ok;
      end
      VECTOR_WSUBU, VECTOR_WSUB: begin
        raw     = b_ext - a_ext;
        invalid = (cur_w != prev_p1) || !cur_ok;
      end
      VECTOR_ADC:   raw = b_ext + a_ext + {63'd0, carry_in};
      VECTOR_SBC:   raw = (vec_operand_type == OPIVV) ? (b_ext - a_ext - {63'd0, mask[0]}) : 64'd0;
      VECTOR_MSBC:  raw = {63'd0, borrow_diff[64]};
      VECTOR_MACC:  raw = product + mask;
      VECTOR_NMSAC: raw = mask - product;
      VECTOR_MADD:  raw = (a_ext * mask) + b_ext;
      VECTOR_ZEXT2, VECTOR_SEXT2: begin
        raw     = b_ext;
        invalid = (cur_w != prev_p1) || !cur_ok;
      end
      VECTOR_ZEXT4, VECTOR_SEXT4: begin
        raw     = b_ext;
        invalid = (cur_w != prev_p2) || !cur_ok;
      end
      VECTOR_ZEXT8, VECTOR_SEXT8: begin
        raw     = b_ext;
        invalid = (cur_w != prev_p3) || !cur_ok;
      end
      default:      invalid = 1'b1;
    endcase
  end

  logic [63:0] pre_trunc;
  assign pre_trunc = invalid ? 64'd0 : (inactive ? vs2 : raw);

  vec_elem_extend u_ext_out (.value(pre_trunc), .vsew(CUR_VSEW), .sign_ext(1'b0), .out(out_val));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else if (alu_signal != ALU_IDLE) begin
      result <= out_val;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && (alu_signal != ALU_IDLE) && invalid)
      $display("vector_lane_alu[%0d] warning: unsupported opcode %0d or width %0d->%0d",
               LANE_INDEX, opcode, PREV_VSEW, CUR_VSEW);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_lane_alu.sv
// ============================================================================
// tb_vector_lane_alu : directed self-checking bench for vector_lane_alu.
//                      Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_lane_alu;
  import vector_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  prev_vsew = 3'd0;
  logic [2:0]  cur_vsew = 3'd0;
  logic        vm = 1'b1;
  logic [63:0] vs1 = 64'd0;
  logic [63:0] vs2 = 64'd0;
  logic [63:0] mask = 64'd0;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs = 32'd0;
  logic [2:0]  alu_signal = 3'd0;
  logic [1:0]  vec_operand_type = 2'd0;
  logic [5:0]  opcode = 6'd0;
  logic [63:0] result;

  int total_cnt = 0;
  int pass_cnt  = 0;

  vector_lane_alu #(.LANE_INDEX(0), .LEN(32), .LONGEST_LEN(64)) dut (
    .clk(clk), .rst(rst), .PREV_VSEW(prev_vsew), .CUR_VSEW(cur_vsew), .vm(vm),
    .vs1(vs1), .vs2(vs2), .mask(mask), .imm(imm), .rs(rs),
    .alu_signal(alu_signal), .vec_operand_type(vec_operand_type),
    .opcode(opcode), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic [1:0] typ,
                     input logic [2:0] pw, input logic [2:0] cw, input logic m,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] mk,
                     input logic [31:0] im, input logic [31:0] r, input logic [63:0] exp);
    @(negedge clk);
    opcode = op; vec_operand_type = typ; prev_vsew = pw; cur_vsew = cw; vm = m;
    vs1 = a; vs2 = b; mask = mk; imm = im; rs = r; alu_signal = 3'd1;
    @(posedge clk);
    #1;
    check(tag, result, exp);
  endtask

  initial begin
    #1;
    check("reset", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run("add8",    VECTOR_ADD,   OPIVV, ONE_BYTE,  ONE_BYTE,   1'b1, 64'hF0, 64'h20, 64'd0, 32'd0, 32'd0, 64'h10);
    run("sub_vi",  VECTOR_SUB,   OPIVI, TWO_BYTE,  TWO_BYTE,   1'b1, 64'd0, 64'h5, 64'd0, 32'hFFFF_FFFF, 32'd0, 64'h6);
    run("sub_msk", VECTOR_SUB,   OPIVI, TWO_BYTE,  TWO_BYTE,   1'b0, 64'd0, 64'h5, 64'd0, 32'hFFFF_FFFF, 32'd0, 64'h5);
    run("wadd",    VECTOR_WADD,  OPIVV, ONE_BYTE,  TWO_BYTE,   1'b1, 64'h80, 64'hFF, 64'd0, 32'd0, 32'd0, 64'hFF7F);
    run("waddu",   VECTOR_WADDU, OPIVV, ONE_BYTE,  TWO_BYTE,   1'b1, 64'h80, 64'hFF, 64'd0, 32'd0, 32'd0, 64'h17F);
    run("wsub",    VECTOR_WSUB,  OPIVV, ONE_BYTE,  TWO_BYTE,   1'b1, 64'h02, 64'h01, 64'd0, 32'd0, 32'd0, 64'hFFFF);
    run("adc",     VECTOR_ADC,   OPIVV, FOUR_BYTE, FOUR_BYTE,  1'b0, 64'hFFFF_FFFF, 64'd0, 64'd1, 32'd0, 32'd0, 64'd0);
    run("adc_vm1", VECTOR_ADC,   OPIVV, FOUR_BYTE, FOUR_BYTE,  1'b1, 64'hFFFF_FFFF, 64'd0, 64'd1, 32'd0, 32'd0, 64'hFFFF_FFFF);
    run("msbc",    VECTOR_MSBC,  OPIVV, FOUR_BYTE, FOUR_BYTE,  1'b1, 64'd1, 64'd0, 64'd0, 32'd0, 32'd0, 64'd1);
    run("msbc_nb", VECTOR_MSBC,  OPIVV, FOUR_BYTE, FOUR_BYTE,  1'b1, 64'd1, 64'd1, 64'd0, 32'd0, 32'd0, 64'd0);
    run("sbc_vv",  VECTOR_SBC,   OPIVV, ONE_BYTE,  ONE_BYTE,   1'b0, 64'd3, 64'd5, 64'd1, 32'd0, 32'd0, 64'd1);
    run("sbc_vx",  VECTOR_SBC,   OPIVX, ONE_BYTE,  ONE_BYTE,   1'b0, 64'd3, 64'd5, 64'd1, 32'd0, 32'd3, 64'd0);
    run("macc",    VECTOR_MACC,  OPIVV, FOUR_BYTE, FOUR_BYTE,  1'b1, 64'd3, 64'd4, 64'd10, 32'd0, 32'd0, 64'd22);
    run("nmsac",   VECTOR_NMSAC, OPIVV, FOUR_BYTE, FOUR_BYTE,  1'b1, 64'd3, 64'd4, 64'd10, 32'd0, 32'd0, 64'hFFFF_FFFE);
    run("madd",    VECTOR_MADD,  OPIVV, FOUR_BYTE, FOUR_BYTE,  1'b1, 64'd3, 64'd4, 64'd10, 32'd0, 32'd0, 64'd34);
    run("add_vx",  VECTOR_ADD,   OPIVX, EIGHT_BYTE, EIGHT_BYTE, 1'b1, 64'd0, 64'd2, 64'd0, 32'd0, 32'hFFFF_FFFF, 64'd1);
    run("zext2",   VECTOR_ZEXT2, OPIVV, ONE_BYTE,  TWO_BYTE,   1'b1, 64'd0, 64'h80, 64'd0, 32'd0, 32'd0, 64'h80);
    run("zext2_bad", VECTOR_ZEXT2, OPIVV, ONE_BYTE, FOUR_BYTE, 1'b1, 64'd0, 64'h80, 64'd0, 32'd0, 32'd0, 64'd0);
    run("sext4",   VECTOR_SEXT4, OPIVV, ONE_BYTE,  FOUR_BYTE,  1'b1, 64'd0, 64'h80, 64'd0, 32'd0, 32'd0, 64'hFFFF_FF80);

    // Idle: result must hold even though inputs change.
    @(negedge clk);
    alu_signal = 3'd0; vs2 = 64'h1234; opcode = VECTOR_ADD;
    @(posedge clk);
    #1;
    check("idle_hold", result, 64'hFFFF_FF80);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run("post_rst", VECTOR_ADD, OPIVV, ONE_BYTE, ONE_BYTE, 1'b1, 64'h01, 64'h02, 64'd0, 32'd0, 32'd0, 64'h03);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/vector_lane_alu.md
Name: vector_lane_alu

Overview:
- Single-lane element ALU of the vector function unit. The dispatcher instantiates LANE_SIZE copies, one per lane, and each copy computes one vector element per cycle.
- Operands arrive zero-extended in 64-bit containers. The registered result is truncated to the destination element width and zero-extended to 64 bits.
- Covers: add/sub, widening add/sub, add/sub with carry/borrow, multiply-accumulate, and zero/sign extension.

Parameters:
- LANE_INDEX, 0, lane number of this instance (identification/debug only; no functional effect).
- LEN, 32, scalar operand width (rs, imm).
- LONGEST_LEN, 64, element container width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- PREV_VSEW  in  3  source element width: 000=8, 001=16, 010=32, 011=64 bits
- CUR_VSEW  in  3  destination element width, same encoding
- vm  in  1  1=unmasked, 0=masked / carry-in from mask
- vs1  in  64  source operand 1, valid in low PREV_VSEW bits
- vs2  in  64  source operand 2
- mask  in  64  mask element (bit0 significant); carries old vd for MACC/NMSAC/MADD
- imm  in  32  sign-extended immediate
- rs  in  32  scalar register operand
- alu_signal  in  3  0=idle, nonzero=compute
- vec_operand_type  in  2  00=OPIVV, 01=OPIVX, 10=OPIVI, 11=OPMVV
- opcode  in  6  operation code, from the shared package
- result  out  64  registered element result

Behaviour:
- Reset: while rst=0, result=0 asynchronously.
- Latency: result updates at each posedge with the function of the inputs sampled at that edge (1 cycle). When alu_signal=0, result holds its value.
- Operand A source:
  - vs1 for OPIVV/OPMVV.
  - rs sign-extended to 64 for OPIVX.
  - imm sign-extended to 64 for OPIVI.
- Operand B is always vs2.
- Before use, both operands are truncated to the PREV_VSEW width, then zero- or sign-extended per the opcode.
- Output: the arithmetic result is truncated to the CUR_VSEW width and zero-extended to 64 bits. All ops wrap modulo 2^width; there is no saturation.
- Opcodes (package values 0..17):
  - ADD: B+A.
  - SUB: B-A.
  - WADDU: zext(B)+zext(A), 2x width.
  - WSUBU: zext(B)-zext(A), 2x width.
  - WADD: sext(B)+sext(A), 2x width.
  - WSUB: sext(B)-sext(A), 2x width.
  - ADC: B+A+mask[0]. Requires vm=0; with vm=1 the carry-in is 0.
  - SBC: B-A-mask[0]. OPIVV only; any other operand type gives result 0.
  - MSBC: result = borrow-out of B-A-(vm?0:mask[0]) at PREV width, in bit0; other bits 0.
  - MACC: A*B+vd, where vd = mask port.
  - NMSAC: vd-A*B.
  - MADD: A*vd+B.
  - ZEXT2/4/8: zero-extend vs2 from PREV width to CUR width.
  - SEXT2/4/8: sign-extend vs2 from PREV width to CUR width.
- Masking applies to all ops except ADC, SBC, MSBC, MACC, NMSAC and MADD:
  - If vm=0 and mask[0]=0, the element is inactive and result = vs2 truncated to CUR width.
  - Otherwise the element is computed.
- Width rules:
  - Widening ops require CUR = PREV+1.
  - ZEXT2/SEXT2 require CUR = PREV+1; ZEXT4/SEXT4 require CUR = PREV+2; ZEXT8/SEXT8 require CUR = PREV+3.
  - A mismatch or unknown opcode yields result 0 and a simulation $display warning.
- Multiply: 64x64 producing a truncated low product, combinational; no multicycle.
- Ops with a non-widening width rule use CUR_VSEW equal to PREV_VSEW; where they differ, computation uses PREV width and the output is truncated to CUR.
- Reset mid-operation: the result clears immediately; on release, the first posedge computes from the current inputs.

Decomposition:
- Shared package vector_alu_pkg holds:
  - opcode constants VECTOR_ADD..VECTOR_SEXT8;
  - VSEW constants ONE_BYTE, TWO_BYTE, FOUR_BYTE, EIGHT_BYTE;
  - operand types OPIVV, OPIVX, OPIVI, OPMVV;
  - the ALU-idle constant.
- One natural sub-module: vec_elem_extend. It takes a 64-bit value, a 3-bit width and a signed flag, truncates the value to the width and zero- or sign-extends it back to 64 bits. It is used for operand conditioning and the ext ops.

Test Plan:
- ADD, OPIVV, PREV=CUR=8-bit, vs1=0xF0, vs2=0x20, vm=1 -> result=0x10 after one edge.
- SUB, OPIVI, 16-bit, imm=0xFFFFFFFF (-1), vs2=0x0005 -> result=0x0006; repeat with vm=0, mask=0 -> result=0x0005.
- WADD, 8->16 bits, vs1=0x80, vs2=0xFF -> result=0xFF7F; WADDU with the same operands -> 0x017F.
- ADC, 32-bit, vs1=0xFFFFFFFF, vs2=0, vm=0, mask=1 -> result=0; MSBC with vs2=0, vs1=1 -> result=1.
- MACC, 32-bit, vs1=3, vs2=4, mask(vd)=10 -> 22; SEXT4, 8->32 bits, vs2=0x80 -> 0xFFFFFF80.
- Assert rst=0 mid-stream -> result=0 immediately; alu_signal=0 after a computation -> result held.
